// File: rtl/note_store_controller_pkg.sv
// Shared constants and types for the note-chart store.
// Chart word layout, sys codes and sequencer states.
package note_store_controller_pkg;

    localparam logic [2:0] SYS_NOTE = 3'b000;
    localparam logic [2:0] SYS_END  = 3'b111;

    localparam int SYS_MSB    = 31;
    localparam int SYS_LSB    = 29;
    localparam int PITCH_MSB  = 28;
    localparam int PITCH_LSB  = 23;
    localparam int STRING_MSB = 22;
    localparam int STRING_LSB = 20;
    localparam int FRET_MSB   = 19;
    localparam int FRET_LSB   = 16;
    localparam int TIME_MSB   = 15;
    localparam int TIME_LSB   = 0;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_CHECK,
        ST_EMIT,
        ST_DONE
    } note_state_t;

    function automatic logic [2:0] word_sys(input logic [31:0] w);
        return w[SYS_MSB:SYS_LSB];
    endfunction

endpackage

// File: rtl/note_store_controller_bram.sv
// Single-port block RAM wrapper with registered read.
// Read data reflects the address of the previous edge.
module note_store_controller_bram #(
    parameter int LOGSIZE = 12,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [LOGSIZE-1:0] i_addr,
    input  logic [WIDTH-1:0]   i_wdata,
    output logic [WIDTH-1:0]   o_rdata
);

    logic [WIDTH-1:0] r_mem [0:(1<<LOGSIZE)-1];
    logic [WIDTH-1:0] r_rdata;

    // Synchronous write and registered read of the same address.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/note_store_controller.sv
// Note-chart store and playback sequencer.
// Loads chart words until the end marker, then releases notes in time order.
module note_store_controller
    import note_store_controller_pkg::*;
#(
    parameter int                 ADDR_W    = 12,
    parameter int                 TIME_W    = 16,
    parameter logic [TIME_W-1:0]  LOOKAHEAD = 16'd2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_en,
    input  logic [31:0]       write_word,
    output logic              write_ready,
    input  logic              reload,
    input  logic              restart,
    input  logic              play_en,
    input  logic [TIME_W-1:0] song_time,
    output logic              note_valid,
    input  logic              note_ready,
    output logic [31:0]       note_word,
    output logic              loaded,
    output logic              overflow,
    output logic [ADDR_W:0]   note_count,
    output logic              done
);

    localparam logic [ADDR_W:0] LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};

    note_state_t       r_state;
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_note_count;
    logic [31:0]       r_hold;
    logic [31:0]       r_note_word;
    logic              r_note_valid;
    logic              r_write_ready;
    logic              r_loaded;
    logic              r_overflow;
    logic              r_done;

    logic              w_is_load;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_rdata;
    logic [2:0]        w_sys;
    logic [TIME_W:0]   w_note_time;
    logic [TIME_W:0]   w_limit;
    logic              w_in_window;

    assign w_sys     = word_sys(write_word);
    assign w_is_load = (r_state == ST_LOAD);
    assign w_we      = w_is_load && write_en && !reload
                       && (w_sys == SYS_NOTE);
    assign w_addr    = w_is_load ? r_wr_ptr[ADDR_W-1:0]
                                 : r_rd_ptr[ADDR_W-1:0];

    // Widened by one bit so song_time + LOOKAHEAD never wraps.
    assign w_note_time = {1'b0, r_hold[TIME_LSB +: TIME_W]};
    assign w_limit     = {1'b0, song_time} + {1'b0, LOOKAHEAD};
    assign w_in_window = (w_note_time <= w_limit);

    note_store_controller_bram #(
        .LOGSIZE (ADDR_W),
        .WIDTH   (32)
    ) u_bram (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (w_addr),
        .i_wdata (write_word),
        .o_rdata (w_rdata)
    );

    // Load/playback sequencer with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_LOAD;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_note_count  <= '0;
            r_hold        <= '0;
            r_note_word   <= '0;
            r_note_valid  <= 1'b0;
            r_write_ready <= 1'b1;
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else if (reload) begin
            r_state       <= ST_LOAD;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_note_count  <= '0;
            r_note_valid  <= 1'b0;
            r_write_ready <= 1'b1;
            r_loaded      <= 1'b0;
            r_overflow    <= 1'b0;
            r_done        <= 1'b0;
        end else if (restart && !w_is_load) begin
            r_state      <= ST_IDLE;
            r_rd_ptr     <= '0;
            r_note_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (write_en && w_sys == SYS_NOTE) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == LAST_ADDR) begin
                            r_note_count  <= FULL_CNT;
                            r_loaded      <= 1'b1;
                            r_overflow    <= 1'b1;
                            r_write_ready <= 1'b0;
                            r_state       <= ST_IDLE;
                        end
                    end else if (write_en && w_sys == SYS_END) begin
                        r_note_count  <= r_wr_ptr;
                        r_loaded      <= 1'b1;
                        r_write_ready <= 1'b0;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (r_note_count == '0) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (play_en) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_hold  <= w_rdata;
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (play_en && w_in_window) begin
                        r_note_word  <= r_hold;
                        r_note_valid <= 1'b1;
                        r_state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (note_ready) begin
                        r_note_valid <= 1'b0;
                        r_rd_ptr     <= r_rd_ptr + 1'b1;
                        if (r_rd_ptr + 1'b1 == r_note_count) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign write_ready = r_write_ready;
    assign note_valid  = r_note_valid;
    assign note_word   = r_note_word;
    assign loaded      = r_loaded;
    assign overflow    = r_overflow;
    assign note_count  = r_note_count;
    assign done        = r_done;

endmodule

// File: doc/note_store_controller.md
# note_store_controller

Parametrised note-chart store and playback sequencer for the game datapath. Accepts a stream of 32-bit chart words from the loader into an internal BRAM until the end-of-data marker, then walks the stored notes in order and presents each one on a valid/ready output once it falls inside a configurable look-ahead window of the current song time. This replaces the fixed-size, load-only metadata store. It adds single-clock operation, reset, overflow detection, restart/reload, and a playback scanner.

## Interface
Parameters:
- ADDR_W, 12, log2 of store depth (DEPTH = 2^ADDR_W words)
- TIME_W, 16, width of note time field and song_time
- LOOKAHEAD, 16'd2000, window in time units; note is released when note_time <= song_time + LOOKAHEAD

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- write_en  in  1  chart word valid
- write_word  in  32  chart word: [31:29] sys (3'b000 note, 3'b111 end), [28:23] pitch, [22:20] string, [19:16] fret, [15:0] time
- write_ready  out  1  store accepting words
- reload  in  1  pulse: discard store, return to loading
- restart  in  1  pulse: rewind playback to first note, keep store
- play_en  in  1  level: scanner may advance
- song_time  in  TIME_W  current song time
- note_valid  out  1  note_word holds a released note
- note_ready  in  1  consumer takes note
- note_word  out  32  released chart word
- loaded  out  1  store complete
- overflow  out  1  sticky: store filled without end marker
- note_count  out  ADDR_W+1  notes stored (end marker excluded)
- done  out  1  all notes emitted

## Operation
- States: LOAD, IDLE, FETCH, WAIT, CHECK, EMIT, DONE.
- LOAD:
  - write_ready=1.
  - A word is accepted when write_en=1.
  - A note word is written at wr_ptr and wr_ptr increments.
  - An end word (sys=3'b111) is not stored. It sets note_count=wr_ptr and loaded=1, then goes to IDLE.
  - Any other sys value is ignored and dropped (no write, no pointer change).
- Overflow: a note accepted at wr_ptr=DEPTH-1 is stored, then note_count=DEPTH, loaded=1, overflow=1, go to IDLE. Words arriving after that are ignored (write_ready=0).
- IDLE:
  - If note_count=0, go to DONE.
  - Else if play_en=1, go to FETCH.
- FETCH: drive BRAM read address rd_ptr, go to WAIT.
- WAIT: BRAM read latency is 1 cycle; register the output into the hold register, go to CHECK.
- CHECK:
  - If {1'b0,time} <= song_time + LOOKAHEAD (computed in TIME_W+1 bits, no wrap), go to EMIT.
  - Otherwise remain in CHECK and re-evaluate every cycle.
  - play_en=0 holds the state.
- EMIT:
  - note_valid=1; note_word is the held word.
  - On note_ready=1: rd_ptr++. If rd_ptr+1 = note_count, go to DONE; else go to FETCH.
- DONE: done=1, hold until restart/reload.
- restart (ignored in LOAD): rd_ptr=0, done=0, note_valid drops; go to IDLE.
- reload (any state): wr_ptr=rd_ptr=0, loaded=0, overflow=0, note_count=0, done=0, note_valid=0; go to LOAD. reload wins over restart.
- write_en outside LOAD is ignored.

## Timing
- Reset values: LOAD state, write_ready=1, note_valid=0, note_word=0, loaded=0, overflow=0, note_count=0, done=0, pointers=0.
- All outputs are registered.
- loaded, note_count and overflow rise the cycle after the accepting edge.
- Playback latency: IDLE with play_en=1 sampled at edge N gives note_valid=1 after edge N+3 if the note is already inside the window.
  - Back-to-back notes: one note per 4 cycles (EMIT→FETCH→WAIT→CHECK→EMIT).
- note_valid and note_word are stable until the handshake. note_valid deasserts the cycle after note_ready=1 is sampled.
- restart/reload take effect on the next edge; the outputs above hold their post-command values from that edge.

## Structure
- Shared package constants:
  - SYS_NOTE=3'b000, SYS_END=3'b111
  - field bit positions (SYS, PITCH, STRING, FRET, TIME)
  - note state enum
- One sub-module: single-port BRAM wrapper, registered read, LOGSIZE=ADDR_W, WIDTH=32.
  - Address mux: wr_ptr in LOAD, rd_ptr otherwise.

## Test plan
- Load three notes at times 100, 200, 300 then end word → loaded=1, note_count=3, overflow=0, write_ready=0.
- song_time=0, LOOKAHEAD=150, play_en=1, note_ready=1 → note 100 emitted. Then scanner stalls in CHECK until song_time=50, when note 200 is emitted. done=1 after note 300 is taken.
- ADDR_W=3, eight notes, no end word → overflow=1, loaded=1, note_count=8. A ninth write is ignored; playback emits exactly 8 notes.
- note_ready held 0 for 10 cycles in EMIT → note_valid stays 1 and note_word is unchanged, rd_ptr is unchanged.
- restart after second note → next note_valid presents note 100 again; note_count is unchanged.
- reload and restart asserted together mid-EMIT → LOAD state, loaded=0, note_valid=0. A new two-note load then succeeds with note_count=2.
- Async reset asserted mid-load → all outputs return to reset values with no clock edge needed.
